// File: rtl/retry_replay_buffer.sv
// Retry/replay buffer: stores every issued payload by ID until released, replays on request,
// and aborts an ID once it has been replayed MaxRetries times.
module retry_replay_buffer #(
  parameter int DataWidth  = 16,
  parameter int IDSize     = 3,
  parameter int MaxRetries = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic [IDSize-1:0]    id_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  input  logic                 retry_valid_i,
  input  logic [IDSize-1:0]    retry_id_i,
  output logic                 retry_ready_o,
  input  logic                 release_valid_i,
  input  logic [IDSize-1:0]    release_id_i,
  output logic                 abort_o,
  output logic [IDSize-1:0]    abort_id_o,
  output logic [IDSize:0]      occupancy_o,
  output logic [15:0]          retry_count_o
);

  localparam int Depth = 2 ** IDSize;
  localparam int CntW  = (MaxRetries < 1) ? 1 : $clog2(MaxRetries + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxRetries);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both 1.
  // valid_o/data_o/id_o never change while valid_o=1 and ready_i=0, and ready_o
  // never looks at valid_i.

  logic [DataWidth-1:0] mem [Depth];
  logic [Depth-1:0]     busy_q, busy_d;
  logic [Depth-1:0]     pending_q, pending_d;
  logic [CntW-1:0]      cnt_q [Depth];
  logic [CntW-1:0]      cnt_d [Depth];
  logic [IDSize-1:0]    next_id_q;
  logic                 valid_q;
  logic [DataWidth-1:0] data_q;
  logic [IDSize-1:0]    id_q;
  logic                 abort_q;
  logic [IDSize-1:0]    abort_id_q;
  logic [IDSize:0]      occ_q;
  logic [15:0]          retry_cnt_q;

  logic                 free;
  logic                 any_pending;
  logic                 replay;
  logic                 accept;
  logic [IDSize-1:0]    replay_id;
  logic                 rel_hit;
  logic                 retry_ok;
  logic                 abort_fire;
  logic                 retry_inc;

  function automatic logic [IDSize:0] popcount(input logic [Depth-1:0] v);
    logic [IDSize:0] n;
    n = '0;
    for (int i = 0; i < Depth; i++) n = n + (IDSize + 1)'(v[i]);
    return n;
  endfunction

  assign free        = !valid_q || ready_i;
  assign any_pending = |pending_q;
  assign ready_o     = free && !busy_q[next_id_q] && !any_pending;
  assign replay      = free && any_pending;
  assign accept      = valid_i && ready_o;
  assign rel_hit     = release_valid_i && busy_q[release_id_i];

  // Lowest-index pending entry wins the replay slot.
  always_comb begin
    replay_id = '0;
    for (int i = Depth - 1; i >= 0; i--) begin
      if (pending_q[i]) replay_id = IDSize'(i);
    end
  end

  // Launches (replay or new beat) are applied before the retry is judged;
  // a release of the same ID overrides the retry entirely.
  always_comb begin
    busy_d     = busy_q;
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    abort_fire = 1'b0;
    retry_inc  = 1'b0;
    retry_ok   = 1'b0;

    if (replay) pending_d[replay_id] = 1'b0;
    if (accept) begin
      busy_d[next_id_q] = 1'b1;
      cnt_d[next_id_q]  = '0;
    end

    retry_ok = retry_valid_i && busy_d[retry_id_i] && !pending_d[retry_id_i] &&
               !(rel_hit && (release_id_i == retry_id_i));

    if (retry_ok) begin
      if (cnt_d[retry_id_i] == MaxCnt) begin
        busy_d[retry_id_i] = 1'b0;
        abort_fire         = 1'b1;
      end else begin
        pending_d[retry_id_i] = 1'b1;
        cnt_d[retry_id_i]     = cnt_d[retry_id_i] + 1'b1;
        retry_inc             = 1'b1;
      end
    end

    if (rel_hit) begin
      busy_d[release_id_i]    = 1'b0;
      pending_d[release_id_i] = 1'b0;
      cnt_d[release_id_i]     = '0;
    end
  end

  // Payload storage carries no reset; busy/pending decide what is meaningful.
  always_ff @(posedge clk_i) begin
    if (accept) mem[next_id_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q      <= '0;
      pending_q   <= '0;
      for (int i = 0; i < Depth; i++) cnt_q[i] <= '0;
      next_id_q   <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      id_q        <= '0;
      abort_q     <= 1'b0;
      abort_id_q  <= '0;
      occ_q       <= '0;
      retry_cnt_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      occ_q     <= popcount(busy_q);
      abort_q   <= abort_fire;
      if (abort_fire) abort_id_q <= retry_id_i;
      if (accept) next_id_q <= next_id_q + 1'b1;
      if (retry_inc && (retry_cnt_q != 16'hFFFF)) retry_cnt_q <= retry_cnt_q + 16'd1;

      if (free) begin
        if (replay) begin
          valid_q <= 1'b1;
          data_q  <= mem[replay_id];
          id_q    <= replay_id;
        end else if (accept) begin
          valid_q <= 1'b1;
          data_q  <= data_i;
          id_q    <= next_id_q;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign valid_o       = valid_q;
  assign data_o        = data_q;
  assign id_o          = id_q;
  assign abort_o       = abort_q;
  assign abort_id_o    = abort_id_q;
  assign occupancy_o   = occ_q;
  assign retry_count_o = retry_cnt_q;
  assign retry_ready_o = 1'b1;

endmodule

// File: tb/tb_retry_replay_buffer.sv
// Directed bench for retry_replay_buffer: streaming, full table, replay order,
// retry limit/abort, release-vs-retry collision, stall and mid-transfer reset.
module tb_retry_replay_buffer;

  localparam int W = 16;
  localparam int I = 3;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] data_o;
  logic [I-1:0] id_o;
  logic         valid_o;
  logic         ready_i;
  logic         retry_valid_i;
  logic [I-1:0] retry_id_i;
  logic         retry_ready_o;
  logic         release_valid_i;
  logic [I-1:0] release_id_i;
  logic         abort_o;
  logic [I-1:0] abort_id_o;
  logic [I:0]   occupancy_o;
  logic [15:0]  retry_count_o;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_d;

  retry_replay_buffer #(.DataWidth(W), .IDSize(I), .MaxRetries(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .id_o(id_o), .valid_o(valid_o), .ready_i(ready_i),
    .retry_valid_i(retry_valid_i), .retry_id_i(retry_id_i), .retry_ready_o(retry_ready_o),
    .release_valid_i(release_valid_i), .release_id_i(release_id_i),
    .abort_o(abort_o), .abort_id_o(abort_id_o),
    .occupancy_o(occupancy_o), .retry_count_o(retry_count_o)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i           = 1'b1;
    valid_i         = 1'b0;
    data_i          = '0;
    ready_i         = 1'b1;
    retry_valid_i   = 1'b0;
    retry_id_i      = '0;
    release_valid_i = 1'b0;
    release_id_i    = '0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid_o"}, 32'(valid_o), 0);
    check({tag, "_data_o"}, 32'(data_o), 0);
    check({tag, "_id_o"}, 32'(id_o), 0);
    check({tag, "_abort_o"}, 32'(abort_o), 0);
    check({tag, "_abort_id_o"}, 32'(abort_id_o), 0);
    check({tag, "_occupancy"}, 32'(occupancy_o), 0);
    check({tag, "_retry_count"}, 32'(retry_count_o), 0);
    check({tag, "_ready_o"}, 32'(ready_o), 1);
    check({tag, "_retry_ready"}, 32'(retry_ready_o), 1);
  endtask

  // Driver: one upstream beat, output checked the cycle after the handshake.
  task automatic send_beat(input string tag, input logic [W-1:0] d, input int exp_id);
    check({tag, "_ready"}, 32'(ready_o), 1);
    valid_i = 1'b1;
    data_i  = d;
    step();
    valid_i = 1'b0;
    check({tag, "_valid"}, 32'(valid_o), 1);
    check({tag, "_id"}, 32'(id_o), 32'(exp_id));
    check({tag, "_data"}, 32'(data_o), 32'(d));
  endtask

  initial begin
    // Reset values
    do_reset();
    check_reset_state("rst0");

    // Streaming: 100 beats, releases one cycle behind, one beat per cycle
    for (int i = 0; i < 100; i++) begin
      check("stream_ready", 32'(ready_o), 1);
      valid_i         = 1'b1;
      data_i          = W'(16'h1000 + i);
      release_valid_i = (i > 0);
      release_id_i    = I'((i + 7) % 8);
      exp_q.push_back(W'(16'h1000 + i));
      step();
      exp_d = exp_q.pop_front();
      check("stream_valid", 32'(valid_o), 1);
      check("stream_data", 32'(data_o), 32'(exp_d));
      check("stream_id", 32'(id_o), 32'(i % 8));
    end
    valid_i         = 1'b0;
    release_valid_i = 1'b1;
    release_id_i    = 3'd3;
    step();
    release_valid_i = 1'b0;
    check("stream_drain_valid", 32'(valid_o), 0);

    // Fill all 8 entries without release
    do_reset();
    for (int i = 0; i < 8; i++) send_beat("fill", W'(16'h2000 + i), i);
    check("full_ready_low", 32'(ready_o), 0);
    step();
    step();
    check("full_occupancy", 32'(occupancy_o), 8);
    check("full_ready_still_low", 32'(ready_o), 0);
    release_valid_i = 1'b1;
    release_id_i    = 3'd0;
    step();
    release_valid_i = 1'b0;
    check("full_release_ready", 32'(ready_o), 1);
    step();
    step();
    check("full_occupancy_after_rel", 32'(occupancy_o), 7);

    // Replay order: A=ID2, B=ID5, retries 5 then 2 while the output is stalled
    do_reset();
    for (int i = 0; i < 6; i++) send_beat("ab", W'(16'h3000 + i), i);
    ready_i       = 1'b0;
    retry_valid_i = 1'b1;
    retry_id_i    = 3'd5;
    step();
    check("ab_hold_valid", 32'(valid_o), 1);
    check("ab_hold_id", 32'(id_o), 5);
    check("ab_hold_data", 32'(data_o), 32'h3005);
    retry_id_i = 3'd2;
    step();
    retry_valid_i = 1'b0;
    check("ab_pending_ready", 32'(ready_o), 0);
    ready_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 16'h3AAA;
    check("ab_pending_ready_free", 32'(ready_o), 0);
    step();
    check("ab_replay1_id", 32'(id_o), 2);
    check("ab_replay1_data", 32'(data_o), 32'h3002);
    check("ab_replay1_ready", 32'(ready_o), 0);
    step();
    check("ab_replay2_id", 32'(id_o), 5);
    check("ab_replay2_data", 32'(data_o), 32'h3005);
    check("ab_after_replay_ready", 32'(ready_o), 1);
    step();
    valid_i = 1'b0;
    check("ab_new_id", 32'(id_o), 6);
    check("ab_new_data", 32'(data_o), 32'h3AAA);
    check("ab_retry_count", 32'(retry_count_o), 2);

    // Retry limit: ID 3 retried four times
    do_reset();
    for (int i = 0; i < 4; i++) send_beat("lim", W'(16'h4000 + i), i);
    step();
    step();
    check("lim_occupancy_before", 32'(occupancy_o), 4);
    for (int k = 1; k <= 3; k++) begin
      retry_valid_i = 1'b1;
      retry_id_i    = 3'd3;
      step();
      retry_valid_i = 1'b0;
      check("lim_retry_count", 32'(retry_count_o), 32'(k));
      check("lim_no_abort", 32'(abort_o), 0);
      step();
      check("lim_replay_valid", 32'(valid_o), 1);
      check("lim_replay_id", 32'(id_o), 3);
      check("lim_replay_data", 32'(data_o), 32'h4003);
      step();
    end
    retry_valid_i = 1'b1;
    retry_id_i    = 3'd3;
    step();
    retry_valid_i = 1'b0;
    check("lim_abort", 32'(abort_o), 1);
    check("lim_abort_id", 32'(abort_id_o), 3);
    check("lim_count_held", 32'(retry_count_o), 3);
    step();
    check("lim_abort_pulse_end", 32'(abort_o), 0);
    check("lim_no_replay_after_abort", 32'(valid_o), 0);
    step();
    check("lim_occupancy_after", 32'(occupancy_o), 3);

    // Release and retry of ID 1 in the same cycle
    do_reset();
    for (int i = 0; i < 2; i++) send_beat("rr", W'(16'h5000 + i), i);
    step();
    retry_valid_i   = 1'b1;
    retry_id_i      = 3'd1;
    release_valid_i = 1'b1;
    release_id_i    = 3'd1;
    step();
    retry_valid_i   = 1'b0;
    release_valid_i = 1'b0;
    check("rr_no_abort", 32'(abort_o), 0);
    check("rr_no_count", 32'(retry_count_o), 0);
    step();
    check("rr_no_replay", 32'(valid_o), 0);
    check("rr_no_abort_late", 32'(abort_o), 0);
    check("rr_occupancy", 32'(occupancy_o), 1);
    retry_valid_i = 1'b1;
    retry_id_i    = 3'd1;
    step();
    retry_valid_i = 1'b0;
    check("rr_freed_retry_ignored", 32'(retry_count_o), 0);

    // Stall with ready_i=0 for 5 cycles, then reset mid-transfer
    do_reset();
    ready_i = 1'b0;
    send_beat("stall", 16'h6001, 0);
    for (int c = 0; c < 5; c++) begin
      valid_i = 1'b1;
      data_i  = W'($urandom_range(0, 16'hFFFF));
      check("stall_ready_low", 32'(ready_o), 0);
      step();
      check("stall_valid", 32'(valid_o), 1);
      check("stall_data", 32'(data_o), 32'h6001);
      check("stall_id", 32'(id_o), 0);
    end
    valid_i = 1'b0;
    rst_i   = 1'b1;
    step();
    rst_i = 1'b0;
    check_reset_state("rst_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
